cve2_stall_mem: RTL
===================

# cve2_stall_mem

Simulation-side memory responder for the core's instruction and data ports. It implements the req/gnt/rvalid protocol from the device end, with pseudo-random grant stalls and a fixed response latency. It gives directed and compliance benches a way to stress the load/store unit and prefetch buffer against back-pressure and multi-cycle responses. It carries its own word array and replaces the shared bus and RAM path for the port it is attached to.

## Interface
Parameters:
- Depth, 4096: memory size in 32-bit words; power of two, ≥ 16.
- Latency, 1: cycles from grant to response, 1..4.
- StallThresh, 0: 0..255. A grant is withheld in any cycle where the LFSR value is below this threshold; 0 means never stall.
- LfsrSeed, 8'hA5: LFSR reset value; 8'h00 is replaced by 8'h01.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request from host; held until granted.
- gnt_o  out  1  grant; the transfer is accepted on any edge where req_i && gnt_o.
- addr_i  in  32  byte address; bits [1:0] are ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one cycle per accepted transfer.
- rdata_o  out  32  read data; 0 for writes, errors, and when rvalid_o = 0.
- err_o  out  1  error flag, qualified by rvalid_o.

## Operation
- **LFSR:** 8-bit Galois, mask 8'hB8, steps every cycle. The registered stall flag is lfsr < StallThresh, recomputed each cycle from the current LFSR value.
- **Grant:** gnt_o = req_i && !stall. It is combinational in req_i and never asserted without req_i.
- **Address check:** word index = addr_i[31:2]. An access is in range when the index is below Depth.
- **Accepted write, in range:** update the bytes with be_i set, at the accept edge. The response is rdata 0, err 0.
- **Accepted read, in range:** capture mem[index] at the accept edge.
  - A write accepted at edge N is visible to a read accepted at edge N+1 or later.
  - No two transfers are ever accepted on the same edge.
- **Out of range:** no memory change. The response is err_o = 1 and rdata_o = 0.
- **Response pipeline:** Latency stages, each holding {valid, err, data}, shifting every cycle.
  - The pipeline output drives rvalid_o, err_o and rdata_o.
  - Responses come out in acceptance order.
  - Up to Latency transfers can be outstanding; there is no additional back-pressure.
- **Host obligations:** addr_i, we_i, be_i and wdata_i stay stable while req_i && !gnt_o. Behaviour under violation is undefined; it is checked by a bench assertion, not by RTL.

## Timing
- **Reset values:**
  - rvalid_o = 0, err_o = 0, rdata_o = 0.
  - LFSR = LfsrSeed (or 8'h01 if the seed is 0), so the stall flag after reset reflects the seed.
  - All pipeline valid bits are 0.
  - Memory contents are not reset.
- **Accept latency:**
  - Accept edge = edge N. rvalid_o is high during the cycle after edge N+Latency-1.
  - Latency = 1 gives the response in the cycle immediately after the accept.
- **Back-to-back:** with no stalls, one accept per cycle and one response per cycle, continuously.
- **Reset mid-operation:** asserting rst_ni discards all in-flight responses immediately. rvalid_o drops in the same cycle, with no response after release. Writes already accepted remain in memory.
- **Wrap-around:** an address beyond Depth*4 never aliases; it always produces err.
- **StallThresh = 255:** the grant is possible only when the LFSR equals 8'hFF, roughly once per 255 cycles. This is legal and must not deadlock.

## Test plan
- **Write then read:** StallThresh=0, Latency=1. Write 0xDEADBEEF to 0x10 with be=4'hF, then immediately read 0x10.
  - Both are granted in their request cycles.
  - rvalid_o appears in each following cycle.
  - The read returns rdata 0xDEADBEEF with err 0.
- **Byte enables:** write 0xFFFFFFFF to 0x20, then write 0x11223344 with be=4'b0101, then read 0x20 → 0xFF22FF44.
- **Out of range:** Depth=4096.
  - Read 0x4000 → rvalid with err_o=1, rdata 0.
  - Write 0xA5A5A5A5 to 0x4000, then read 0x0 → original contents unchanged, err 0.
- **Latency ordering:** Latency=3. Four back-to-back reads of 0x0, 0x4, 0x8, 0xC, preloaded with 1, 2, 3, 4.
  - rvalid_o is high 3..6 cycles after the first accept.
  - Data arrives in the order 1, 2, 3, 4.
- **Random stalls:** StallThresh=128, 500 random reads and writes against a scoreboard.
  - Every accept yields exactly one response with the correct data.
  - gnt_o is never high without req_i.
  - At least one grant is withheld.
- **Mid-flight reset:** Latency=3. Accept a write to 0x40, then accept a read of 0x40, then pull rst_ni low for 2 cycles.
  - rvalid_o goes low at once and stays low after release.
  - A fresh read of 0x40 returns the written value.

Source files
------------

// File: rtl/cve2_stall_mem.sv
// Memory responder for a req/gnt/rvalid port with LFSR-driven grant stalls
// and a fixed-depth response pipeline.
module cve2_stall_mem #(
    parameter int unsigned Depth       = 4096,
    parameter int unsigned Latency     = 1,
    parameter int unsigned StallThresh = 0,
    parameter logic [7:0]  LfsrSeed    = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int unsigned AW      = $clog2(Depth);
    localparam logic [7:0]  SeedEff = (LfsrSeed == 8'h00) ? 8'h01 : LfsrSeed;
    localparam logic [7:0]  Thresh  = 8'(StallThresh);

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic is_stall(input logic [7:0] s);
        return (s < Thresh);
    endfunction

    logic [7:0]    r_lfsr;
    logic          r_stall;
    logic [7:0]    w_lfsr_next;
    logic          w_accept;
    logic          w_in_range;
    logic [31:0]   w_word;
    logic [AW-1:0] w_idx;
    logic          w_ld_err;
    logic [31:0]   w_ld_data;

    logic [31:0]   r_mem  [Depth];
    logic          r_vld  [Latency];
    logic          r_err  [Latency];
    logic [31:0]   r_data [Latency];

    // Grant, address decode and the response entering the pipeline
    always_comb begin
        w_lfsr_next = lfsr_step(r_lfsr);
        gnt_o       = req_i && !r_stall;
        w_accept    = req_i && !r_stall;
        // The full word index is compared so high addresses never alias
        w_word      = addr_i >> 2;
        w_idx       = w_word[AW-1:0];
        w_in_range  = (w_word < 32'(Depth));
        w_ld_err    = 1'b0;
        w_ld_data   = 32'h0000_0000;
        if (w_accept) begin
            if (!w_in_range) begin
                w_ld_err = 1'b1;
            end else if (!we_i) begin
                w_ld_data = r_mem[w_idx];
            end else begin
                w_ld_data = 32'h0000_0000;
            end
        end else begin
            w_ld_err  = 1'b0;
            w_ld_data = 32'h0000_0000;
        end
    end

    // LFSR and the stall flag derived from it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr  <= SeedEff;
            r_stall <= is_stall(SeedEff);
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_stall <= is_stall(w_lfsr_next);
        end
    end

    // Byte-masked write into the word array; contents survive reset
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_accept && we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 takes the accept, later stages shift
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                r_vld[i]  <= 1'b0;
                r_err[i]  <= 1'b0;
                r_data[i] <= 32'h0000_0000;
            end
        end else begin
            r_vld[0]  <= w_accept;
            r_err[0]  <= w_ld_err;
            r_data[0] <= w_ld_data;
            for (int i = 1; i < Latency; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_err[i]  <= r_err[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign rvalid_o = r_vld[Latency-1];
    assign err_o    = r_err[Latency-1];
    assign rdata_o  = r_data[Latency-1];

endmodule
